// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, scan FSM states
// and the press/release event record carried through the event FIFO.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_CHECK  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } key_evt_t;

    // Physical (row, column) position to the printed key legend.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_A;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_B;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with a show-ahead head; a push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives one row low at a time, debounces each key over
// consecutive scans and queues press/release events for a consumer.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC = 512,
    parameter int DEB_SCANS  = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cols,
    output logic [3:0]  rows,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic        evt_press,
    output logic [15:0] key_state,
    output logic        p1_up,
    output logic        p1_dn,
    output logic        p2_up,
    output logic        p2_dn,
    output logic        overflow
);

    localparam int         CW       = $clog2(SETTLE_CYC);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [2:0] DEB_LAST = 3'(DEB_SCANS - 1);

    logic [3:0]        cols_s1_q, cols_s2_q;
    scan_state_e       state_q, state_d;
    logic [1:0]        r_q, r_d, c_q, c_d;
    logic [CW-1:0]     settle_cnt_q, settle_cnt_d;
    // Debounce counters are indexed by position {r,c}; key_state by key code.
    logic [15:0][2:0]  deb_cnt_q, deb_cnt_d;
    logic [15:0]       key_state_q, key_state_d;
    logic [3:0]        rows_q;
    logic              overflow_q, overflow_d;
    logic              p1_up_q, p1_dn_q, p2_up_q, p2_dn_q;

    logic              push;
    key_evt_t          evt_in, evt_out;
    logic              fifo_full, fifo_empty;
    logic [3:0]        cur_code;
    logic              raw_pressed;

    assign cur_code    = key_code(r_q, c_q);
    assign raw_pressed = ~cols_s2_q[c_q];

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        c_d          = c_q;
        settle_cnt_d = settle_cnt_q;
        deb_cnt_d    = deb_cnt_q;
        key_state_d  = key_state_q;
        push         = 1'b0;
        evt_in       = '0;

        case (state_q)
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_CHECK;
                    c_d          = 2'd0;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: begin
                if (raw_pressed != key_state_q[cur_code]) begin
                    if (deb_cnt_q[{r_q, c_q}] == DEB_LAST) begin
                        key_state_d[cur_code] = raw_pressed;
                        deb_cnt_d[{r_q, c_q}] = '0;
                        push                  = 1'b1;
                        evt_in.code           = cur_code;
                        evt_in.press          = raw_pressed;
                    end else begin
                        deb_cnt_d[{r_q, c_q}] = deb_cnt_q[{r_q, c_q}] + 3'd1;
                    end
                end else begin
                    deb_cnt_d[{r_q, c_q}] = '0;
                end

                if (c_q == 2'd3) begin
                    state_d = ST_SETTLE;
                    r_d     = r_q + 2'd1;
                    c_d     = 2'd0;
                end else begin
                    c_d = c_q + 2'd1;
                end
            end
        endcase
    end

    // Only a push that finds the FIFO full with no simultaneous pop is lost.
    assign overflow_d = overflow_q | (push && fifo_full && !(evt_ready && !fifo_empty));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_s1_q    <= 4'hF;
            cols_s2_q    <= 4'hF;
            state_q      <= ST_SETTLE;
            r_q          <= 2'd0;
            c_q          <= 2'd0;
            settle_cnt_q <= '0;
            deb_cnt_q    <= '0;
            key_state_q  <= '0;
            rows_q       <= 4'hF;
            overflow_q   <= 1'b0;
            p1_up_q      <= 1'b0;
            p1_dn_q      <= 1'b0;
            p2_up_q      <= 1'b0;
            p2_dn_q      <= 1'b0;
        end else begin
            cols_s1_q    <= cols;
            cols_s2_q    <= cols_s1_q;
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            settle_cnt_q <= settle_cnt_d;
            deb_cnt_q    <= deb_cnt_d;
            key_state_q  <= key_state_d;
            rows_q       <= ~(4'b0001 << r_d);
            overflow_q   <= overflow_d;
            p1_up_q      <= key_state_q[1] & ~key_state_q[4];
            p1_dn_q      <= key_state_q[4] & ~key_state_q[1];
            p2_up_q      <= key_state_q[KEY_A] & ~key_state_q[KEY_B];
            p2_dn_q      <= key_state_q[KEY_B] & ~key_state_q[KEY_A];
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_evt_t))
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (evt_ready),
        .din_i   (evt_in),
        .dout_o  (evt_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rows      = rows_q;
    assign evt_valid = ~fifo_empty;
    assign evt_code  = evt_out.code;
    assign evt_press = evt_out.press;
    assign key_state = key_state_q;
    assign overflow  = overflow_q;
    assign p1_up     = p1_up_q;
    assign p1_dn     = p1_dn_q;
    assign p2_up     = p2_up_q;
    assign p2_dn     = p2_dn_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
module tb_keypad_scan_ctrl;

    localparam int SCAN = 80;   // 4 rows x (16 settle + 4 check) cycles

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cols, rows;
    logic        evt_valid, evt_ready, evt_press;
    logic [3:0]  evt_code;
    logic [15:0] key_state;
    logic        p1_up, p1_dn, p2_up, p2_dn, overflow;

    logic [15:0] pressed;
    logic [4:0]  evq [$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SETTLE_CYC(16), .DEB_SCANS(3), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cols(cols), .rows(rows),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_press(evt_press), .key_state(key_state),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .overflow(overflow)
    );

    function automatic logic [3:0] tb_code(input int r, input int c);
        case (r * 4 + c)
            0: return 4'd1;   1: return 4'd2;   2: return 4'd3;   3: return 4'd10;
            4: return 4'd4;   5: return 4'd5;   6: return 4'd6;   7: return 4'd11;
            8: return 4'd7;   9: return 4'd8;  10: return 4'd9;  11: return 4'd12;
            12: return 4'd14; 13: return 4'd0; 14: return 4'd15; default: return 4'd13;
        endcase
    endfunction

    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rows[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[tb_code(r, c)]) cols[c] = 1'b0;
    end

    always @(negedge clk)
        if (rst_n && evt_valid && evt_ready) evq.push_back({evt_code, evt_press});

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Return at the first settle cycle of row 0.
    task automatic align();
        int k = 0;
        while (rows == 4'b1110 && k < 200) begin tick(1); k++; end
        while (rows != 4'b1110 && k < 400) begin tick(1); k++; end
        if (k >= 400) begin
            n_chk++; n_fail++;
            $display("FAIL align: rows=%b, expected 1110 within 400 cycles", rows);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; evt_ready = 1'b1; pressed = '0;
        tick(3);
        n_chk++; if (rows !== 4'hF) begin n_fail++; $display("FAIL reset_rows: got %b exp 1111", rows); end
        n_chk++; if ({evt_valid, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {evt_valid, overflow}); end
        n_chk++; if (key_state !== 16'h0) begin n_fail++; $display("FAIL reset_keys: got %h exp 0000", key_state); end
        n_chk++; if ({p1_up, p1_dn, p2_up, p2_dn} !== 4'b0) begin n_fail++; $display("FAIL reset_paddles: got %b exp 0000", {p1_up, p1_dn, p2_up, p2_dn}); end
        rst_n = 1'b1;
    endtask

    task automatic test_hold();
        evq.delete();
        align();
        pressed[5] = 1'b1;
        tick(2 * SCAN);
        n_chk++; if (key_state[5] !== 1'b0 || evq.size() != 0) begin n_fail++; $display("FAIL hold_2scans: key5=%b events=%0d exp 0/0", key_state[5], evq.size()); end
        tick(SCAN);
        n_chk++; if (key_state[5] !== 1'b1) begin n_fail++; $display("FAIL hold_3scans: key5=%b exp 1", key_state[5]); end
        tick(2 * SCAN);
        n_chk++; if (evq.size() != 1 || evq[0] !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL hold_press_evt: n=%0d head=%h exp 1 event 0b", evq.size(), evq.size() ? evq[0] : 5'h0); end
        evq.delete();
        pressed[5] = 1'b0;
        tick(4 * SCAN);
        n_chk++; if (evq.size() != 1 || evq[0] !== {4'd5, 1'b0} || key_state[5] !== 1'b0) begin n_fail++; $display("FAIL hold_release_evt: n=%0d head=%h key5=%b exp 1 event 0a key 0", evq.size(), evq.size() ? evq[0] : 5'h0, key_state[5]); end
        evq.delete();
    endtask

    task automatic test_bounce();
        align();
        pressed[7] = 1'b1; tick(2 * SCAN);
        pressed[7] = 1'b0; tick(SCAN);
        pressed[7] = 1'b1; tick(2 * SCAN);
        pressed[7] = 1'b0; tick(3 * SCAN);
        n_chk++; if (evq.size() != 0 || key_state !== 16'h0) begin n_fail++; $display("FAIL bounce: events=%0d keys=%h exp 0/0000", evq.size(), key_state); end
        evq.delete();
    endtask

    task automatic test_simultaneous();
        align();
        pressed[1] = 1'b1; pressed[3] = 1'b1;
        tick(4 * SCAN);
        n_chk++; if (evq.size() != 2 || evq[0] !== {4'd1, 1'b1} || evq[1] !== {4'd3, 1'b1}) begin n_fail++; $display("FAIL simul_order: n=%0d e0=%h e1=%h exp 03 07", evq.size(), evq.size() > 0 ? evq[0] : 5'h0, evq.size() > 1 ? evq[1] : 5'h0); end
        n_chk++; if (key_state !== 16'h000A) begin n_fail++; $display("FAIL simul_keys: got %h exp 000a", key_state); end
        evq.delete();
        pressed[1] = 1'b0; pressed[3] = 1'b0;
        tick(4 * SCAN);
        evq.delete();
    endtask

    task automatic test_paddles();
        int k = 0;
        align();
        pressed[1] = 1'b1;
        while (key_state[1] !== 1'b1 && k < 4 * SCAN) begin tick(1); k++; end
        n_chk++; if (evt_valid !== 1'b1 || evt_code !== 4'd1 || evt_press !== 1'b1) begin n_fail++; $display("FAIL evt_latency: valid=%b code=%0d press=%b exp 1/1/1", evt_valid, evt_code, evt_press); end
        n_chk++; if (p1_up !== 1'b0) begin n_fail++; $display("FAIL paddle_reg_delay: p1_up=%b exp 0", p1_up); end
        tick(1);
        n_chk++; if ({p1_up, p1_dn} !== 2'b10) begin n_fail++; $display("FAIL paddle_p1up: got %b exp 10", {p1_up, p1_dn}); end
        pressed[4] = 1'b1;
        tick(4 * SCAN);
        n_chk++; if ({p1_up, p1_dn} !== 2'b00) begin n_fail++; $display("FAIL paddle_both: got %b exp 00", {p1_up, p1_dn}); end
        pressed[1] = 1'b0; pressed[4] = 1'b0; pressed[11] = 1'b1;
        tick(4 * SCAN);
        n_chk++; if ({p1_up, p1_dn, p2_up, p2_dn} !== 4'b0001) begin n_fail++; $display("FAIL paddle_p2dn: got %b exp 0001", {p1_up, p1_dn, p2_up, p2_dn}); end
        pressed[11] = 1'b0;
        tick(4 * SCAN);
        evq.delete();
    endtask

    task automatic test_overflow();
        logic [4:0] exp_q [$];
        logic ok;
        evt_ready = 1'b0;
        align();
        pressed = 16'h0CFE;   // keys 1..7, A, B
        tick(4 * SCAN);
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
        n_chk++; if (key_state !== 16'h0CFE) begin n_fail++; $display("FAIL ovf_keys: got %h exp 0cfe", key_state); end
        n_chk++; if (evt_valid !== 1'b1 || evt_code !== 4'd1) begin n_fail++; $display("FAIL ovf_head: valid=%b code=%0d exp 1/1", evt_valid, evt_code); end
        tick(5);
        n_chk++; if (evt_code !== 4'd1 || evt_press !== 1'b1) begin n_fail++; $display("FAIL ovf_head_stable: code=%0d press=%b exp 1/1", evt_code, evt_press); end
        evt_ready = 1'b1;
        tick(20);
        exp_q = '{{4'd1,1'b1}, {4'd2,1'b1}, {4'd3,1'b1}, {4'd10,1'b1},
                  {4'd4,1'b1}, {4'd5,1'b1}, {4'd6,1'b1}, {4'd11,1'b1}};
        ok = (evq.size() == 8);
        for (int i = 0; i < 8 && ok; i++) if (evq[i] !== exp_q[i]) ok = 1'b0;
        n_chk++; if (!ok) begin n_fail++; $display("FAIL ovf_drain: n=%0d exp 8 events 1,2,3,10,4,5,6,11", evq.size()); end
        evq.delete();
        pressed = '0;
        tick(4 * SCAN);
        n_chk++; if (evq.size() != 9 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_release: n=%0d ovf=%b exp 9/1", evq.size(), overflow); end
        evq.delete();
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        align();
        pressed[2] = 1'b1;
        tick(3 * SCAN + 17);   // row 0 CHECK, column 1
        n_chk++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: valid=%b exp 1", evt_valid); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (rows !== 4'hF || evt_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: rows=%b valid=%b exp 1111/0", rows, evt_valid); end
        n_chk++; if (key_state !== 16'h0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: keys=%h ovf=%b exp 0000/0", key_state, overflow); end
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        n_chk++; if (rows !== 4'b1110) begin n_fail++; $display("FAIL rstmid_row0: rows=%b exp 1110", rows); end
        tick(18);
        n_chk++; if (rows !== 4'b1110) begin n_fail++; $display("FAIL rstmid_row0_end: rows=%b exp 1110", rows); end
        tick(1);
        n_chk++; if (rows !== 4'b1101 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_row1: rows=%b valid=%b exp 1101/0", rows, evt_valid); end
        evt_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_bounce();
        test_simultaneous();
        test_paddles();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
